// File: rtl/bitwise_logic_pipe_if.sv
// Operand/result handshake bundle for bitwise_logic_pipe.
// Carries out_pop only when BLU_POPCOUNT_EN is defined.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_c;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;
`ifdef BLU_POPCOUNT_EN
  logic [$clog2(WIDTH+1)-1:0] out_pop;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, out_ready,
    input  in_ready, out_valid, out_c, out_zero, op_count, out_pop
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
    output in_ready, out_valid, out_c, out_zero, op_count, out_pop
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_op, in_acc, out_ready,
    input  in_ready, out_valid, out_c, out_zero, op_count
  );
  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc, out_ready,
    output in_ready, out_valid, out_c, out_zero, op_count
  );
`endif
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage bitwise XOR/AND/OR/AUTO unit with accumulator operand and valid/ready flow.
// Define BLU_POPCOUNT_EN to add the registered out_pop population count.
module bitwise_logic_pipe #(
  parameter int               WIDTH    = 8,
  parameter int               CNT_W    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input logic                 clk_i,
  input logic                 rst_i,
  bitwise_logic_pipe_if.slave bus
);
  localparam int POP_W = $clog2(WIDTH + 1);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_c_q, s1_c_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic             out_zero_q, out_zero_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             adv1, adv2, accept;
  logic [WIDTH-1:0] op_b, res;

`ifdef BLU_POPCOUNT_EN
  logic [POP_W-1:0] out_pop_q, out_pop_d;

  function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction
`endif

  always_comb begin
    adv2   = !out_valid_q || bus.out_ready;
    adv1   = !s1_valid_q || adv2;
    accept = bus.in_valid && adv1;
    op_b   = bus.in_acc ? acc_q : bus.in_b;

    unique case (bus.in_op)
      2'b01:   res = bus.in_a ^ op_b;
      2'b10:   res = bus.in_a & op_b;
      2'b11:   res = bus.in_a | op_b;
      default: res = bus.in_a[WIDTH-1] ? (bus.in_a & op_b) : (bus.in_a ^ op_b);
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_c_d      = s1_c_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_zero_d  = out_zero_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`ifdef BLU_POPCOUNT_EN
    out_pop_d   = out_pop_q;
`endif

    // The accumulator follows every accepted result, not only in_acc beats.
    if (accept) begin
      acc_d = res;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (adv1) begin
      s1_valid_d = accept;
      if (accept) s1_c_d = res;
    end

    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_c_d    = s1_c_q;
        out_zero_d = (s1_c_q == '0);
`ifdef BLU_POPCOUNT_EN
        out_pop_d  = popcount(s1_c_q);
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_c_q      <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_zero_q  <= 1'b0;
      acc_q       <= ACC_INIT;
      cnt_q       <= '0;
`ifdef BLU_POPCOUNT_EN
      out_pop_q   <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_c_q      <= s1_c_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_zero_q  <= out_zero_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`ifdef BLU_POPCOUNT_EN
      out_pop_q   <= out_pop_d;
`endif
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_c     = out_c_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.op_count  = cnt_q;
`ifdef BLU_POPCOUNT_EN
  assign bus.out_pop   = out_pop_q;
`endif
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench: directed plan steps plus random traffic against a queue-based model.
// A second instance with CNT_W=4 shares the stimulus to exercise counter wrap.
module tb_bitwise_logic_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bitwise_logic_pipe_if #(.WIDTH(8), .CNT_W(8)) u_if ();
  bitwise_logic_pipe_if #(.WIDTH(8), .CNT_W(4)) u_if4 ();

  bitwise_logic_pipe #(.WIDTH(8), .CNT_W(8), .ACC_INIT(8'h00)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(u_if.slave));
  bitwise_logic_pipe #(.WIDTH(8), .CNT_W(4), .ACC_INIT(8'h00)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .bus(u_if4.slave));

  assign u_if4.in_valid  = u_if.in_valid;
  assign u_if4.in_a      = u_if.in_a;
  assign u_if4.in_b      = u_if.in_b;
  assign u_if4.in_op     = u_if.in_op;
  assign u_if4.in_acc    = u_if.in_acc;
  assign u_if4.out_ready = u_if.out_ready;

  typedef struct {
    logic [7:0]  c;
    int unsigned e;
  } beat_t;

  beat_t       q[$];
  logic [7:0]  got[$];
  logic [7:0]  acc_m;
  int unsigned cnt_m;
  int unsigned edge_n;
  int          checks;
  int          failures;
  bit          last_acc;

  function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd1:    return a ^ b;
      2'd2:    return a & b;
      2'd3:    return a | b;
      default: return (a >= 8'h80) ? (a & b) : (a ^ b);
    endcase
  endfunction

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input bit accsel, input bit ordy);
    bit         rdy_m, vld_m;
    logic [7:0] r;
    u_if.in_valid  = v;
    u_if.in_a      = a;
    u_if.in_b      = b;
    u_if.in_op     = op;
    u_if.in_acc    = accsel;
    u_if.out_ready = ordy;
    #1;
    rdy_m = (q.size() < 2) || ordy;
    vld_m = (q.size() > 0) && (q[0].e < edge_n);
    chk("in_ready", 16'(u_if.in_ready), 16'(rdy_m));
    chk("out_valid", 16'(u_if.out_valid), 16'(vld_m));
    chk("op_count", 16'(u_if.op_count), 16'(cnt_m % 256));
    chk("op_count4", 16'(u_if4.op_count), 16'(cnt_m % 16));
    if (vld_m) begin
      chk("out_c", 16'(u_if.out_c), 16'(q[0].c));
      chk("out_zero", 16'(u_if.out_zero), 16'(q[0].c == 8'h00));
`ifdef BLU_POPCOUNT_EN
      chk("out_pop", 16'(u_if.out_pop), 16'($countones(q[0].c)));
`endif
      if (ordy) begin
        got.push_back(u_if.out_c);
        void'(q.pop_front());
      end
    end
    last_acc = v && rdy_m;
    if (last_acc) begin
      r = ref_op(a, accsel ? acc_m : b, op);
      q.push_back('{c: r, e: edge_n + 1});
      acc_m = r;
      cnt_m++;
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    u_if.in_valid  = 1'b0;
    u_if.in_a      = 8'h00;
    u_if.in_b      = 8'h00;
    u_if.in_op     = 2'd0;
    u_if.in_acc    = 1'b0;
    u_if.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    edge_n++;
    #1 rst = 1'b0;
    q.delete();
    got.delete();
    acc_m = 8'h00;
    cnt_m = 0;
    @(negedge clk);
  endtask

  logic [7:0] bp_a[4];
  logic [7:0] bp_exp[4];
  int         idx;
  int         guard;

  initial begin
    checks   = 0;
    failures = 0;
    edge_n   = 0;

    do_reset();
    chk("rst_out_valid", 16'(u_if.out_valid), 16'd0);
    chk("rst_out_c", 16'(u_if.out_c), 16'd0);
    chk("rst_out_zero", 16'(u_if.out_zero), 16'd0);
    chk("rst_op_count", 16'(u_if.op_count), 16'd0);
    chk("rst_in_ready", 16'(u_if.in_ready), 16'd1);
`ifdef BLU_POPCOUNT_EN
    chk("rst_out_pop", 16'(u_if.out_pop), 16'd0);
`endif

    // AUTO mode: MSB of A picks XOR or AND
    tick(1'b1, 8'h35, 8'h0F, 2'd0, 1'b0, 1'b1);
    tick(1'b1, 8'hB5, 8'h0F, 2'd0, 1'b0, 1'b1);
    drain(3);
    chk("auto_xor", 16'(got_at(0)), 16'h3A);
    chk("auto_and", 16'(got_at(1)), 16'h05);

    got.delete();
    tick(1'b1, 8'h50, 8'h0A, 2'd3, 1'b0, 1'b1);
    tick(1'b1, 8'hFF, 8'hFF, 2'd1, 1'b0, 1'b1);
    tick(1'b1, 8'hF0, 8'h3C, 2'd2, 1'b0, 1'b1);
    drain(3);
    chk("op_or", 16'(got_at(0)), 16'h5A);
    chk("op_xor", 16'(got_at(1)), 16'h00);
    chk("op_and", 16'(got_at(2)), 16'h30);

    got.delete();
    tick(1'b1, 8'h0F, 8'h00, 2'd1, 1'b0, 1'b1);
    tick(1'b1, 8'hFF, 8'h55, 2'd1, 1'b1, 1'b1);
    tick(1'b1, 8'hF0, 8'hAA, 2'd1, 1'b1, 1'b1);
    drain(3);
    chk("acc_0", 16'(got_at(0)), 16'h0F);
    chk("acc_1", 16'(got_at(1)), 16'hF0);
    chk("acc_2", 16'(got_at(2)), 16'h00);

    // Backpressure: four beats offered with the sink stalled
    got.delete();
    bp_a   = '{8'h11, 8'h22, 8'h44, 8'h88};
    bp_exp = '{8'h1E, 8'h2D, 8'h4B, 8'h87};
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, bp_a[idx], 8'h0F, 2'd1, 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    chk("bp_accepted", 16'(u_if.op_count - 8'd8), 16'd2);
    chk("bp_in_ready", 16'(u_if.in_ready), 16'd0);
    chk("bp_hold_c", 16'(u_if.out_c), 16'h1E);
    guard = 0;
    while (idx < 4 && guard < 12) begin
      tick(1'b1, bp_a[idx], 8'h0F, 2'd1, 1'b0, 1'b1);
      if (last_acc) idx++;
      guard++;
    end
    drain(3);
    for (int i = 0; i < 4; i++) chk("bp_order", 16'(got_at(i)), 16'(bp_exp[i]));

    // Random traffic with random sink stalls
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0));
    drain(3);

    // Counter wrap on the CNT_W=4 instance
    do_reset();
    idx = 0;
    guard = 0;
    while (idx < 17 && guard < 200) begin
      tick(1'b1, 8'($urandom), 8'($urandom), 2'd1, 1'b0, 1'($urandom_range(0, 1)));
      if (last_acc) idx++;
      guard++;
    end
    chk("wrap_op_count4", 16'(u_if4.op_count), 16'd1);
    chk("wrap_op_count8", 16'(u_if.op_count), 16'd17);
    drain(3);

    // Reset with two beats in flight
    do_reset();
    tick(1'b1, 8'h3C, 8'h0F, 2'd1, 1'b0, 1'b0);
    tick(1'b1, 8'h77, 8'h01, 2'd3, 1'b0, 1'b0);
    do_reset();
    chk("mid_out_valid", 16'(u_if.out_valid), 16'd0);
    chk("mid_op_count", 16'(u_if.op_count), 16'd0);
    tick(1'b1, 8'h12, 8'hFF, 2'd1, 1'b1, 1'b1);
    drain(4);
    chk("mid_acc_init", 16'(got_at(0)), 16'h12);
    chk("mid_no_stale", 16'(got.size()), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
